// File: rtl/systolic_mm_if.sv
// Stream bundle for the systolic multiplier: operand beats in, row-major results out.
interface systolic_mm_if #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int AW = 64
) ();
    localparam int IW = $clog2(N*N);

    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] west_vec;
    logic [N*DW-1:0] north_vec;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_data;
    logic [IW-1:0]   out_idx;

    modport master (
        output in_valid, west_vec, north_vec, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );

    modport slave (
        input  in_valid, west_vec, north_vec, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/systolic_mm_param.sv
// N x N output-stationary systolic multiplier C = A x B (A is N x K, B is K x N).
// Unskewed beats are staggered per lane, accumulated in place, then drained row-major.
module systolic_mm_param #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int AW = 64,
    parameter int K  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    systolic_mm_if.slave bus
);
    localparam int IW = $clog2(N*N);
    localparam int RW = $clog2(N);
    localparam int BW = (K > 1) ? $clog2(K) : 1;
    localparam int FW = $clog2(2*N-1);
    localparam int PW = 2*DW;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] row, col;
    logic [IW-1:0] idx;
    logic          accept, clr, hs;

    assign accept = (state == S_LOAD) && bus.in_valid;
    assign clr    = (state == S_IDLE) && start;
    assign hs     = (state == S_DRAIN) && bus.out_ready;

    // NOTE: state registers use <= so every flop samples pre-edge values, independent of process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                busy         = 1'b1;
                bus.in_ready = 1'b1;
                if (accept && beat_cnt == BW'(K-1)) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                busy = 1'b1;
                // Last PE update lands 2N-2 cycles after the final accept.
                if (flush_cnt == FW'(2*N-2)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready && idx == IW'(N*N-1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row       <= '0;
            col       <= '0;
            idx       <= '0;
        end else if (clr) begin
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row       <= '0;
            col       <= '0;
            idx       <= '0;
        end else begin
            if (accept)             beat_cnt  <= beat_cnt + 1'b1;
            if (state == S_FLUSH)   flush_cnt <= flush_cnt + 1'b1;
            if (hs) begin
                idx <= idx + 1'b1;
                if (col == RW'(N-1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Lane l carries row l of A and column l of B; both are delayed l cycles.
    logic [DW-1:0] sk_a [N];
    logic [DW-1:0] sk_b [N];
    logic          sk_t [N];

    for (genvar l = 0; l < N; l++) begin : g_skew
        logic [DW-1:0] a_lane, b_lane;
        assign a_lane = accept ? bus.west_vec[l*DW +: DW]  : '0;
        assign b_lane = accept ? bus.north_vec[l*DW +: DW] : '0;
        if (l == 0) begin : g_pass
            assign sk_a[l] = a_lane;
            assign sk_b[l] = b_lane;
            assign sk_t[l] = accept;
        end else begin : g_dly
            logic [DW-1:0] a_q [l];
            logic [DW-1:0] b_q [l];
            logic          t_q [l];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst || clr) begin
                    for (int s = 0; s < l; s++) begin
                        a_q[s] <= '0;
                        b_q[s] <= '0;
                        t_q[s] <= 1'b0;
                    end
                end else begin
                    a_q[0] <= a_lane;
                    b_q[0] <= b_lane;
                    t_q[0] <= accept;
                    for (int s = 1; s < l; s++) begin
                        a_q[s] <= a_q[s-1];
                        b_q[s] <= b_q[s-1];
                        t_q[s] <= t_q[s-1];
                    end
                end
            end
            assign sk_a[l] = a_q[l-1];
            assign sk_b[l] = b_q[l-1];
            assign sk_t[l] = t_q[l-1];
        end
    end

    logic [DW-1:0]        pe_a  [N][N];
    logic [DW-1:0]        pe_b  [N][N];
    logic                 pe_ta [N][N];
    logic                 pe_tb [N][N];
    logic [DW-1:0]        a_in  [N][N];
    logic [DW-1:0]        b_in  [N][N];
    logic                 ta_in [N][N];
    logic                 tb_in [N][N];
    logic signed [PW-1:0] prod  [N][N];
    logic [AW-1:0]        acc   [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0]  = sk_a[i];
            ta_in[i][0] = sk_t[i];
            for (int j = 1; j < N; j++) begin
                a_in[i][j]  = pe_a[i][j-1];
                ta_in[i][j] = pe_ta[i][j-1];
            end
        end
        for (int j = 0; j < N; j++) begin
            b_in[0][j]  = sk_b[j];
            tb_in[0][j] = sk_t[j];
            for (int i = 1; i < N; i++) begin
                b_in[i][j]  = pe_b[i-1][j];
                tb_in[i][j] = pe_tb[i-1][j];
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                prod[i][j] = PW'($signed(a_in[i][j])) * PW'($signed(b_in[i][j]));
    end

    // NOTE: the accumulator array is reset explicitly because it must read as zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || clr) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pe_a[i][j]  <= '0;
                    pe_b[i][j]  <= '0;
                    pe_ta[i][j] <= 1'b0;
                    pe_tb[i][j] <= 1'b0;
                    acc[i][j]   <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pe_a[i][j]  <= a_in[i][j];
                    pe_b[i][j]  <= b_in[i][j];
                    pe_ta[i][j] <= ta_in[i][j];
                    pe_tb[i][j] <= tb_in[i][j];
                    if (ta_in[i][j] && tb_in[i][j])
                        acc[i][j] <= acc[i][j] + AW'(prod[i][j]);
                end
        end
    end

    assign bus.out_data = (state == S_DRAIN) ? acc[row][col] : '0;
    assign bus.out_idx  = (state == S_DRAIN) ? idx : '0;
endmodule

// File: tb/tb_systolic_mm_param.sv
// Directed bench for systolic_mm_param (N=4, K=4): identity, bubbles, backpressure, wrap, reset, start noise.
module tb_systolic_mm_param;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 64;
    localparam int K  = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    systolic_mm_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    systolic_mm_param #(.N(N), .DW(DW), .AW(AW), .K(K)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mat_a [N][K];
    logic [DW-1:0] mat_b [K][N];
    logic [AW-1:0] exp_c [N*N];

    task automatic idle_inputs();
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.west_vec  = '0;
        bus.north_vec = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic drive_beat(input int k);
        bus.in_valid = 1'b1;
        for (int i = 0; i < N; i++) bus.west_vec[i*DW +: DW] = mat_a[i][k];
        for (int j = 0; j < N; j++) bus.north_vec[j*DW +: DW] = mat_b[k][j];
    endtask

    task automatic drive_garbage(input logic vld);
        bus.in_valid  = vld;
        bus.west_vec  = {$urandom, $urandom, $urandom, $urandom};
        bus.north_vec = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_identity_b_ramp();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) mat_a[i][k] = (i == k) ? 32'd1 : 32'd0;
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) mat_b[k][j] = DW'(k*4 + j);
        for (int x = 0; x < N*N; x++) exp_c[x] = AW'(x);
    endtask

    task automatic set_ones_identity();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) mat_a[i][k] = 32'd1;
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) mat_b[k][j] = (k == j) ? 32'd1 : 32'd0;
        for (int x = 0; x < N*N; x++) exp_c[x] = 64'd1;
    endtask

    task automatic set_uniform(input logic [DW-1:0] v, input logic [AW-1:0] e);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) mat_a[i][k] = v;
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) mat_b[k][j] = v;
        for (int x = 0; x < N*N; x++) exp_c[x] = e;
    endtask

    // Starts a job from IDLE, feeds K beats, then waits for the first valid result.
    task automatic load_job(input bit gap, input bit noise);
        int k   = 0;
        int cyc = 0;
        int n   = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = noise;
        while (k < K) begin
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL load_in_ready: beat %0d cycle %0d got %b want 1", k, cyc, bus.in_ready);
            end
            if (gap && (cyc % 2 == 1)) drive_garbage(1'b0);
            else begin
                drive_beat(k);
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        drive_garbage(noise);
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n != 2*N) begin
            n_bad++;
            $display("FAIL flush_latency: got %0d negedges want %0d", n, 2*N);
        end
    endtask

    // Drains all results with a repeating out_ready pattern, then checks the done pulse.
    task automatic drain_job(input logic [3:0] ready_pat, input bit noise);
        int exp_idx = 0;
        int hs      = 0;
        int cyc     = 0;
        while (exp_idx < N*N && cyc < 400) begin
            bus.out_ready = ready_pat[cyc % 4];
            if (noise) drive_garbage(1'b1);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL drain_valid: cycle %0d got valid=%b busy=%b want 1/1", cyc, bus.out_valid, busy);
            end
            n_cmp++;
            if (bus.out_idx !== 4'(exp_idx)) begin
                n_bad++;
                $display("FAIL drain_idx: cycle %0d got %0d want %0d", cyc, bus.out_idx, exp_idx);
            end
            n_cmp++;
            if (bus.out_data !== exp_c[exp_idx]) begin
                n_bad++;
                $display("FAIL drain_data: idx %0d got %0h want %0h", exp_idx, bus.out_data, exp_c[exp_idx]);
            end
            if (bus.out_ready && bus.out_valid) begin
                exp_idx++;
                hs++;
            end
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (hs != N*N) begin
            n_bad++;
            $display("FAIL handshake_count: got %0d want %0d", hs, N*N);
        end
        n_cmp++;
        if (done !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse: got done=%b valid=%b busy=%b want 1/0/0", done, bus.out_valid, busy);
        end
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL after_done: cycle %0d got done=%b busy=%b in_ready=%b want 0/0/0",
                         c, done, busy, bus.in_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if ({busy, done, bus.in_ready, bus.out_valid} !== 4'b0 || bus.out_data !== '0 || bus.out_idx !== '0) begin
            n_bad++;
            $display("FAIL %s: got busy=%b done=%b in_ready=%b out_valid=%b data=%0h idx=%0d want all 0",
                     tag, busy, done, bus.in_ready, bus.out_valid, bus.out_data, bus.out_idx);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_release");
    endtask

    task automatic test_identity();
        set_identity_b_ramp();
        load_job(1'b0, 1'b0);
        drain_job(4'b1111, 1'b0);
    endtask

    task automatic test_bubbles();
        set_identity_b_ramp();
        load_job(1'b1, 1'b0);
        drain_job(4'b1111, 1'b0);
    endtask

    task automatic test_backpressure();
        set_uniform('1, 64'd4);
        load_job(1'b0, 1'b0);
        drain_job(4'b1001, 1'b0);
    endtask

    task automatic test_wrap();
        set_uniform(32'h8000_0000, 64'd0);
        load_job(1'b0, 1'b0);
        drain_job(4'b1111, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        set_identity_b_ramp();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive_beat(0);
        @(negedge clk);
        drive_beat(1);
        @(negedge clk);
        drive_beat(2);
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset_in_load");
        @(negedge clk);
        idle_inputs();
        check_all_zero("held_in_reset");
        rst = 1'b1;
        set_ones_identity();
        load_job(1'b0, 1'b0);
        drain_job(4'b1111, 1'b0);
    endtask

    task automatic test_start_ignored();
        set_identity_b_ramp();
        load_job(1'b0, 1'b1);
        start = 1'b1;
        drain_job(4'b1011, 1'b1);
    endtask

    task automatic test_back_to_back();
        set_ones_identity();
        load_job(1'b0, 1'b0);
        drain_job(4'b1111, 1'b0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_bubbles();
        test_backpressure();
        test_wrap();
        test_reset_mid_load();
        test_start_ignored();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
